// File: rtl/bacc_pkg.sv
// Shared types, thresholds and card helpers for the baccarat controller.
package bacc_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned RANK_W  = 4;

    typedef enum logic [3:0] {
        S_RST,
        S_P1,
        S_D1,
        S_P2,
        S_D2,
        S_EVAL,
        S_P3,
        S_BANK,
        S_D3,
        S_DONE
    } state_t;

    localparam logic [SCORE_W-1:0] NATURAL_MIN     = SCORE_W'(8);
    localparam logic [SCORE_W-1:0] PLAYER_DRAW_MAX = SCORE_W'(5);
    localparam logic [SCORE_W-1:0] BANKER_STAND    = SCORE_W'(7);

    // Face cards and tens count as zero; 0 (no card) also maps to zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [RANK_W-1:0] rank);
        if (rank >= RANK_W'(10)) begin
            return SCORE_W'(0);
        end
        return SCORE_W'(rank);
    endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card decision after the player has drawn a third card.
import bacc_pkg::*;

module banker_draw_rule (
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       draw
);

    logic [3:0] v;

    // Draw decision from the banker's two-card total and the player's third card value.
    always_comb begin
        v    = card_value(pcard3);
        draw = 1'b0;
        if (dscore < BANKER_STAND) begin
            case (dscore)
                4'd0, 4'd1, 4'd2: draw = 1'b1;
                4'd3:             draw = (v != 4'd8);
                4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
                4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
                4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
                default:          draw = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/deal_fsm.sv
// Baccarat deal controller: sequences card loads, applies drawing rules,
// and declares the winner. Optional round tallies under DEAL_FSM_TALLY_EN.
import bacc_pkg::*;

module deal_fsm
`ifdef DEAL_FSM_TALLY_EN
#(
    parameter int unsigned WIN_CNT_W = 4
)
`endif
(
    input  logic       clk,
    input  logic       resetb,
    input  logic [3:0] pscore,
    input  logic [3:0] dscore,
    input  logic [3:0] pcard3,
    output logic       load_pcard1,
    output logic       load_pcard2,
    output logic       load_pcard3,
    output logic       load_dcard1,
    output logic       load_dcard2,
    output logic       load_dcard3,
    output logic       player_win_light,
    output logic       dealer_win_light,
`ifdef DEAL_FSM_TALLY_EN
    output logic [WIN_CNT_W-1:0] pwin_cnt,
    output logic [WIN_CNT_W-1:0] dwin_cnt,
    output logic [WIN_CNT_W-1:0] tie_cnt,
`endif
    output logic       round_done
);

    state_t state_q;
    state_t state_nxt;
    logic   banker_draw;
    logic   enter_done;
    logic   plight_q;
    logic   dlight_q;

    banker_draw_rule u_banker_draw_rule (
        .dscore (dscore),
        .pcard3 (pcard3),
        .draw   (banker_draw)
    );

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic: fixed four-card deal, then natural / third-card rules.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_RST:  state_nxt = S_P1;
            S_P1:   state_nxt = S_D1;
            S_D1:   state_nxt = S_P2;
            S_P2:   state_nxt = S_D2;
            S_D2:   state_nxt = S_EVAL;
            S_EVAL: begin
                // Illegal scores above 9 fall into the natural branch.
                if ((pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN)) begin
                    state_nxt = S_DONE;
                end else if (pscore <= PLAYER_DRAW_MAX) begin
                    state_nxt = S_P3;
                end else if (dscore <= PLAYER_DRAW_MAX) begin
                    // Player stood: banker draws on the same 0..5 threshold.
                    state_nxt = S_D3;
                end else begin
                    state_nxt = S_DONE;
                end
            end
            S_P3:   state_nxt = S_BANK;
            S_BANK: state_nxt = banker_draw ? S_D3 : S_DONE;
            S_D3:   state_nxt = S_DONE;
            S_DONE: state_nxt = S_DONE;
            default: state_nxt = S_RST;
        endcase
    end

    assign enter_done = resetb && (state_q != S_DONE) && (state_nxt == S_DONE);

    // Win lights latched from final scores on entry to S_DONE, cleared by reset.
    always_ff @(posedge clk) begin
        if (!resetb) begin
            plight_q <= 1'b0;
            dlight_q <= 1'b0;
        end else if (enter_done) begin
            plight_q <= (pscore >= dscore);
            dlight_q <= (dscore >= pscore);
        end
    end

    // Moore output decode, forced low while reset is asserted.
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        round_done       = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
        if (resetb) begin
            case (state_q)
                S_P1:   load_pcard1 = 1'b1;
                S_D1:   load_dcard1 = 1'b1;
                S_P2:   load_pcard2 = 1'b1;
                S_D2:   load_dcard2 = 1'b1;
                S_P3:   load_pcard3 = 1'b1;
                S_D3:   load_dcard3 = 1'b1;
                S_DONE: round_done  = 1'b1;
                default: ;
            endcase
            player_win_light = plight_q;
            dealer_win_light = dlight_q;
        end
    end

`ifdef DEAL_FSM_TALLY_EN
    localparam logic [WIN_CNT_W-1:0] CNT_MAX = '1;

    // Power-on zero only; reset deliberately leaves tallies alone.
    logic [WIN_CNT_W-1:0] pwin_q = '0;
    logic [WIN_CNT_W-1:0] dwin_q = '0;
    logic [WIN_CNT_W-1:0] tie_q  = '0;

    // Saturating outcome counters bumped once per completed round.
    always_ff @(posedge clk) begin
        if (enter_done) begin
            if (pscore > dscore) begin
                if (pwin_q != CNT_MAX) pwin_q <= pwin_q + WIN_CNT_W'(1);
            end else if (dscore > pscore) begin
                if (dwin_q != CNT_MAX) dwin_q <= dwin_q + WIN_CNT_W'(1);
            end else begin
                if (tie_q != CNT_MAX) tie_q <= tie_q + WIN_CNT_W'(1);
            end
        end
    end

    assign pwin_cnt = resetb ? pwin_q : '0;
    assign dwin_cnt = resetb ? dwin_q : '0;
    assign tie_cnt  = resetb ? tie_q  : '0;
`endif

endmodule

// File: tb/tb_deal_fsm.sv
// Self-checking bench for deal_fsm with a card-datapath model and a
// rules-level reference model of a baccarat round.
module tb_deal_fsm;

    logic       clk = 1'b0;
    logic       resetb = 1'b0;
    logic [3:0] pscore = 4'd0;
    logic [3:0] dscore = 4'd0;
    logic [3:0] pcard3 = 4'd0;
    logic load_pcard1, load_pcard2, load_pcard3;
    logic load_dcard1, load_dcard2, load_dcard3;
    logic player_win_light, dealer_win_light, round_done;
`ifdef DEAL_FSM_TALLY_EN
    logic [3:0] pwin_cnt, dwin_cnt, tie_cnt;
`endif

    deal_fsm dut (
        .clk              (clk),
        .resetb           (resetb),
        .pscore           (pscore),
        .dscore           (dscore),
        .pcard3           (pcard3),
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light),
`ifdef DEAL_FSM_TALLY_EN
        .pwin_cnt         (pwin_cnt),
        .dwin_cnt         (dwin_cnt),
        .tie_cnt          (tie_cnt),
`endif
        .round_done       (round_done)
    );

    always #5 clk = ~clk;

    // Strobe bit order: 0 p1, 1 d1, 2 p2, 3 d2, 4 p3, 5 d3.
    logic [5:0] strobes;
    assign strobes = {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    logic [8:0] obs;
    assign obs = {strobes, round_done, player_win_light, dealer_win_light};

    int vectors = 0;
    int miscompares = 0;

    int hand [6];
    int card [6];
    logic [5:0] exp_seq [$];
    bit exp_pw, exp_dw;
    int tally_p = 0, tally_d = 0, tally_t = 0;

    // Banker draw chart: row = banker two-card total, column = player third card value.
    string btab [8] = '{"DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDDD", "DDDDDDDDSD",
                        "SSDDDDDDSS", "SSSSDDDDSS", "SSSSSSDDSS", "SSSSSSSSSS"};

    typedef struct {
        int p1, d1, p2, d2, p3, d3;
        int done;
        bit pw, dw;
    } vec_t;
    vec_t tbl [6];

    function automatic int val(input int rank);
        return (rank >= 10) ? 0 : rank;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
        end
    endtask

    // Datapath model: capture loaded cards on the falling edge and rescore.
    task automatic dp_update();
        for (int i = 0; i < 6; i++) begin
            if (strobes[i]) card[i] = hand[i];
        end
        pscore = 4'((val(card[0]) + val(card[2]) + val(card[4])) % 10);
        dscore = 4'((val(card[1]) + val(card[3]) + val(card[5])) % 10);
        pcard3 = 4'(card[4]);
    endtask

    task automatic dp_clear();
        for (int i = 0; i < 6; i++) card[i] = 0;
        pscore = 4'd0;
        dscore = 4'd0;
        pcard3 = 4'd0;
    endtask

    // Reference round: which cards get dealt and who wins.
    task automatic build_model();
        int ps, ds, v3;
        bit nat, pdraw, bdraw;
        exp_seq = {};
        exp_seq.push_back(6'b000001);
        exp_seq.push_back(6'b000010);
        exp_seq.push_back(6'b000100);
        exp_seq.push_back(6'b001000);
        exp_seq.push_back(6'b000000);
        ps = (val(hand[0]) + val(hand[2])) % 10;
        ds = (val(hand[1]) + val(hand[3])) % 10;
        nat = (ps >= 8) || (ds >= 8);
        pdraw = !nat && (ps <= 5);
        if (pdraw) begin
            exp_seq.push_back(6'b010000);
            exp_seq.push_back(6'b000000);
            v3 = val(hand[4]);
            bdraw = (btab[ds].getc(v3) == "D");
            ps = (ps + v3) % 10;
        end else begin
            bdraw = !nat && (ds <= 5);
        end
        if (bdraw) begin
            exp_seq.push_back(6'b100000);
            ds = (ds + val(hand[5])) % 10;
        end
        exp_pw = (ps >= ds);
        exp_dw = (ds >= ps);
    endtask

    task automatic tally_update(input bit pw, input bit dw);
        if (pw && dw) begin
            if (tally_t < 15) tally_t++;
        end else if (pw) begin
            if (tally_p < 15) tally_p++;
        end else begin
            if (tally_d < 15) tally_d++;
        end
    endtask

    task automatic tally_check(input string name);
`ifdef DEAL_FSM_TALLY_EN
        check(name, {20'd0, pwin_cnt, dwin_cnt, tie_cnt},
              {20'd0, 4'(tally_p), 4'(tally_d), 4'(tally_t)});
`else
        if (name.len() < 0) $display("%s", name);
`endif
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetb = 1'b0;
        dp_clear();
        @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {23'd0, obs}, 32'd0);
        resetb = 1'b1;
    endtask

    // One round; tdone = 0 uses the model for done cycle and lights.
    task automatic run_round(input int p1, input int d1, input int p2, input int d2,
                             input int p3, input int d3, input int tdone,
                             input bit tpw, input bit tdw, input int abort_at);
        int done;
        bit pw, dw;
        logic [8:0] e;
        hand = '{p1, d1, p2, d2, p3, d3};
        build_model();
        if (tdone > 0) begin
            done = tdone; pw = tpw; dw = tdw;
        end else begin
            done = exp_seq.size() + 1; pw = exp_pw; dw = exp_dw;
        end
        do_reset();
        for (int k = 1; k <= done + 2; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < done) e = {((k - 1) < exp_seq.size()) ? exp_seq[k - 1] : 6'd0, 3'b000};
            else          e = {6'd0, 1'b1, pw, dw};
            check($sformatf("round_cyc%0d", k), {23'd0, obs}, {23'd0, e});
            if (k == abort_at) begin
                resetb = 1'b0;
                @(posedge clk);
                @(negedge clk);
                check("abort_reset_outputs", {23'd0, obs}, 32'd0);
                resetb = 1'b1;
                dp_clear();
                @(posedge clk);
                @(negedge clk);
                check("abort_release_p1", {23'd0, obs}, {23'd0, 6'b000001, 3'b000});
                tally_check("abort_tally");
                return;
            end
            dp_update();
        end
        tally_update(pw, dw);
        tally_check("round_tally");
    endtask

    initial begin
        tbl[0] = '{p1: 4, d1: 2,  p2: 5,  d2: 3,  p3: 1,  d3: 1, done: 6, pw: 1'b1, dw: 1'b0};
        tbl[1] = '{p1: 1, d1: 2,  p2: 2,  d2: 4,  p3: 7,  d3: 3, done: 9, pw: 1'b0, dw: 1'b1};
        tbl[2] = '{p1: 1, d1: 1,  p2: 1,  d2: 2,  p3: 12, d3: 5, done: 9, pw: 1'b0, dw: 1'b1};
        tbl[3] = '{p1: 1, d1: 1,  p2: 1,  d2: 2,  p3: 8,  d3: 5, done: 8, pw: 1'b0, dw: 1'b1};
        tbl[4] = '{p1: 3, d1: 13, p2: 4,  d2: 7,  p3: 1,  d3: 1, done: 6, pw: 1'b1, dw: 1'b1};
        tbl[5] = '{p1: 6, d1: 4,  p2: 10, d2: 11, p3: 1,  d3: 3, done: 7, pw: 1'b0, dw: 1'b1};

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("por_outputs", {23'd0, obs}, 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_round(tbl[i].p1, tbl[i].d1, tbl[i].p2, tbl[i].d2, tbl[i].p3, tbl[i].d3,
                      tbl[i].done, tbl[i].pw, tbl[i].dw, 0);
        end

        // Reset while in S_P3 (cycle 6 of the player/banker draw deal).
        run_round(1, 2, 2, 4, 7, 3, 9, 1'b0, 1'b1, 6);

        // Illegal player score above 9 counts as a natural.
        do_reset();
        pscore = 4'd12;
        dscore = 4'd3;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 5)
                check("illegal_eval", {23'd0, obs}, 32'd0);
            if (k >= 6)
                check("illegal_done", {23'd0, obs}, {23'd0, 6'd0, 3'b110});
        end
        tally_update(1'b1, 1'b0);
        tally_check("illegal_tally");

        for (int r = 0; r < 50; r++) begin
            run_round(int'($urandom_range(13, 1)), int'($urandom_range(13, 1)),
                      int'($urandom_range(13, 1)), int'($urandom_range(13, 1)),
                      int'($urandom_range(13, 1)), int'($urandom_range(13, 1)),
                      0, 1'b0, 1'b0, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
